// File: rtl/gpr_trace_pkg.sv
// -----------------------------------------------------------------------------
// gpr_trace_pkg
// Shared constants and types for the GPR trace sequencer:
//   - trace beat kind codes (PC / PSR / GPR)
//   - sequencer FSM state encoding
//   - delta slot layout (one captured writeback per record)
// -----------------------------------------------------------------------------
package gpr_trace_pkg;

  localparam int unsigned NUM_GPR    = 32;
  // PC + PSR + one beat per architectural register.
  localparam int unsigned FULL_BEATS = NUM_GPR + 2;

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_PSR = 2'd1;
  localparam logic [1:0] KIND_GPR = 2'd2;

  localparam logic [4:0] LAST_GPR = 5'(NUM_GPR - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPc,
    StPsr,
    StGpr,
    StDgpr
  } state_e;

  typedef struct packed {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
  } delta_slot_t;

endpackage

// File: rtl/gpr_shadow_file.sv
// -----------------------------------------------------------------------------
// gpr_shadow_file
// Shadow copy of the 32 x 32-bit GPR file plus a snapshot taken at each
// accepted retire. The snapshot is read through a registered port so the
// sequencer can present GPR payloads straight from a flop.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all storage)
//   wb_en         writeback strobe (index 0 writes are dropped)
//   wb_index      writeback register index
//   wb_data       writeback data
//   snap_en       copy shadow (including same-cycle writeback) into snapshot
//   rd_en         load rd_data from snapshot[rd_idx]
//   rd_idx        snapshot read index
//   rd_data       registered snapshot read data
// -----------------------------------------------------------------------------
module gpr_shadow_file
  import gpr_trace_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_index,
  input  logic [31:0] wb_data,
  input  logic        snap_en,
  input  logic        rd_en,
  input  logic [4:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [31:0] shadow_q [NUM_GPR];
  logic [31:0] shadow_d [NUM_GPR];
  logic [31:0] snap_q   [NUM_GPR];
  logic [31:0] rd_data_q;

  // shadow_d already carries this cycle's writeback, so snapshotting it gives
  // the same-cycle bypass for free.
  always_comb begin
    shadow_d = shadow_q;
    if (wb_en && (wb_index != 5'd0)) begin
      shadow_d[wb_index] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
      rd_data_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (snap_en) begin
        snap_q <= shadow_d;
      end
      if (rd_en) begin
        rd_data_q <= snap_q[rd_idx];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gpr_trace_sequencer.sv
// -----------------------------------------------------------------------------
// gpr_trace_sequencer
// Turns retire / GPR-writeback strobes into an ordered stream of trace beats
// (PC, PSR, then either all 32 GPRs or the single GPR written by the retiring
// instruction) over a valid/ready handshake.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   retire         instruction retired this cycle
//   retire_pc      PC of the retiring instruction
//   psr            status word sampled with retire
//   wb_gpr_en      GPR writeback valid
//   wb_gpr_index   writeback register index
//   wb_gpr_data    writeback data
//   cfg_full       1 = full dump, 0 = delta; sampled at accept
//   out_valid      beat valid
//   out_ready      sink accepts the beat
//   out_kind       0 = PC, 1 = PSR, 2 = GPR
//   out_idx        register index for GPR beats, 0 otherwise
//   out_data       beat payload
//   out_last       final beat of the record
//   busy           record in progress
//   drop_cnt       saturating count of retires dropped while busy
//
// All outputs are decoded from state flops only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module gpr_trace_sequencer
  import gpr_trace_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      psr,
  input  logic             wb_gpr_en,
  input  logic [4:0]       wb_gpr_index,
  input  logic [31:0]      wb_gpr_data,
  input  logic             cfg_full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [4:0]       out_idx,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q;
  logic [31:0]       psr_q;
  logic              full_q;
  delta_slot_t       slot_q;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              hs;
  logic              accept;
  logic              rd_en;
  logic [31:0]       gpr_rd_data;

  assign hs = out_valid && out_ready;
  // Idle, or the closing beat of the current record leaves this cycle.
  assign accept = retire && ((state_q == StIdle) || (hs && out_last));

  // Prefetch the next snapshot entry as the current beat leaves, so the GPR
  // payload is already in its flop when the state advances.
  assign rd_en = hs && (((state_q == StPsr) && full_q) ||
                        ((state_q == StGpr) && (cnt_q != LAST_GPR)));

  gpr_shadow_file u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_gpr_en),
    .wb_index (wb_gpr_index),
    .wb_data  (wb_gpr_data),
    .snap_en  (accept),
    .rd_en    (rd_en),
    .rd_idx   (cnt_d),
    .rd_data  (gpr_rd_data)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
      psr_q   <= '0;
      full_q  <= 1'b0;
      slot_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      if (accept) begin
        pc_q     <= retire_pc;
        psr_q    <= psr;
        full_q   <= cfg_full;
        slot_q.en   <= wb_gpr_en && (wb_gpr_index != 5'd0);
        slot_q.idx  <= wb_gpr_index;
        slot_q.data <= wb_gpr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: ;
      StPc: begin
        if (hs) state_d = StPsr;
      end
      StPsr: begin
        if (hs) begin
          if (full_q) begin
            state_d = StGpr;
            cnt_d   = '0;
          end else if (slot_q.en) begin
            state_d = StDgpr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGpr: begin
        if (hs) begin
          if (cnt_q == LAST_GPR) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StDgpr: begin
        if (hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Accept only fires from idle or on the closing handshake, so it can
    // override whatever the record-end branch chose.
    if (accept) begin
      state_d = StPc;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (retire && !accept && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_kind = KIND_PC;
    out_idx  = '0;
    out_data = '0;
    out_last = 1'b0;
    unique case (state_q)
      StIdle: ;
      StPc: begin
        out_kind = KIND_PC;
        out_data = pc_q;
      end
      StPsr: begin
        out_kind = KIND_PSR;
        out_data = psr_q;
        out_last = !full_q && !slot_q.en;
      end
      StGpr: begin
        out_kind = KIND_GPR;
        out_idx  = cnt_q;
        out_data = gpr_rd_data;
        out_last = (cnt_q == LAST_GPR);
      end
      StDgpr: begin
        out_kind = KIND_GPR;
        out_idx  = slot_q.idx;
        out_data = slot_q.data;
        out_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_valid = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gpr_trace_sequencer.sv
module tb_gpr_trace_sequencer;
  import gpr_trace_pkg::*;

  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int unsigned CW      = 8;
  localparam int unsigned DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          retire;
  logic [31:0]   retire_pc;
  logic [31:0]   psr;
  logic          wb_gpr_en;
  logic [4:0]    wb_gpr_index;
  logic [31:0]   wb_gpr_data;
  logic          cfg_full;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_kind;
  logic [4:0]    out_idx;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  gpr_trace_sequencer #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .retire       (retire),
    .retire_pc    (retire_pc),
    .psr          (psr),
    .wb_gpr_en    (wb_gpr_en),
    .wb_gpr_index (wb_gpr_index),
    .wb_gpr_data  (wb_gpr_data),
    .cfg_full     (cfg_full),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kind     (out_kind),
    .out_idx      (out_idx),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  // Reference model: expected beats of the record in flight, shadow GPRs,
  // drop count.
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ref_gpr [32];
  int unsigned ref_drop;
  bit          fresh_reset;
  int          n_tests;
  int          n_fail;
  int          obs_beats;

  bit          prev_stall;
  logic [1:0]  prev_kind;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [1:0] k, input logic [4:0] i, input logic [31:0] d,
                           input logic l);
    beat_t b;
    b.kind = k;
    b.idx  = i;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // One clock: drive inputs, check current outputs against the model, advance
  // the model by the rules for this cycle's inputs, then cross the edge.
  task automatic step(input logic r, input logic ret, input logic [31:0] pc,
                      input logic [31:0] ps, input logic we, input logic [4:0] wi,
                      input logic [31:0] wd, input logic fl, input logic rdy);
    beat_t       b;
    bit          hs;
    bit          acc;
    logic [31:0] nxt [32];

    rst          = r;
    retire       = ret;
    retire_pc    = pc;
    psr          = ps;
    wb_gpr_en    = we;
    wb_gpr_index = wi;
    wb_gpr_data  = wd;
    cfg_full     = fl;
    out_ready    = rdy;

    check_eq("valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
    check_eq("drop_cnt", 32'(drop_cnt), ref_drop);
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      check_eq("kind", 32'(out_kind), 32'(b.kind));
      check_eq("idx", 32'(out_idx), 32'(b.idx));
      check_eq("data", out_data, b.data);
      check_eq("last", 32'(out_last), 32'(b.last));
    end else if (fresh_reset) begin
      check_eq("rst_kind", 32'(out_kind), 32'd0);
      check_eq("rst_idx", 32'(out_idx), 32'd0);
      check_eq("rst_data", out_data, 32'd0);
      check_eq("rst_last", 32'(out_last), 32'd0);
    end
    if (prev_stall) begin
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_kind", 32'(out_kind), 32'(prev_kind));
      check_eq("stall_idx", 32'(out_idx), 32'(prev_idx));
      check_eq("stall_data", out_data, prev_data);
      check_eq("stall_last", 32'(out_last), 32'(prev_last));
    end
    prev_stall = out_valid && !rdy && !r;
    prev_kind  = out_kind;
    prev_idx   = out_idx;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && rdy && !r) obs_beats++;

    hs  = (exp_q.size() != 0) && rdy;
    acc = ret && ((exp_q.size() == 0) || (hs && exp_q.size() == 1));
    nxt = ref_gpr;
    if (we && wi != 5'd0) nxt[wi] = wd;

    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) ref_gpr[i] = '0;
      ref_drop    = 0;
      fresh_reset = 1'b1;
    end else begin
      if (hs) b = exp_q.pop_front();
      if (ret && !acc && ref_drop < DROP_MAX) ref_drop++;
      if (acc) begin
        fresh_reset = 1'b0;
        push_beat(KIND_PC, 5'd0, pc, 1'b0);
        push_beat(KIND_PSR, 5'd0, ps, 1'b0);
        if (fl) begin
          for (int i = 0; i < 32; i++) push_beat(KIND_GPR, 5'(i), nxt[i], i == 31);
        end else if (we && wi != 5'd0) begin
          push_beat(KIND_GPR, wi, wd, 1'b1);
        end else begin
          exp_q[exp_q.size() - 1].last = 1'b1;
        end
      end
      ref_gpr = nxt;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, rdy);
  endtask

  task automatic rnd_step(input int unsigned ret_pct, input int unsigned rdy_pct,
                          input int unsigned full_pct);
    step(1'b0, $urandom_range(99) < ret_pct, $urandom, $urandom, 1'($urandom_range(1)),
         5'($urandom_range(31)), $urandom, $urandom_range(99) < full_pct,
         $urandom_range(99) < rdy_pct);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    obs_beats   = 0;
    ref_drop    = 0;
    fresh_reset = 1'b1;
    prev_stall  = 1'b0;
    prev_kind   = '0;
    prev_idx    = '0;
    prev_data   = '0;
    prev_last   = 1'b0;
    for (int i = 0; i < 32; i++) ref_gpr[i] = '0;

    rst = 1'b1; retire = 1'b0; retire_pc = '0; psr = '0; wb_gpr_en = 1'b0;
    wb_gpr_index = '0; wb_gpr_data = '0; cfg_full = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Full dump after a gr5 writeback.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1);
    obs_beats = 0;
    step(1'b0, 1'b1, 32'h80, 32'h3, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle(36, 1'b1);
    check_eq("full_beat_count", 32'(obs_beats), FULL_BEATS);

    // Delta with same-cycle writeback.
    obs_beats = 0;
    step(1'b0, 1'b1, 32'h100, 32'h7, 1'b1, 5'd7, 32'hDEAD, 1'b0, 1'b1);
    idle(5, 1'b1);
    check_eq("delta_beat_count", 32'(obs_beats), 32'd3);

    // gr0 writes are discarded: full dump, then delta with no GPR beat.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle(36, 1'b1);
    obs_beats = 0;
    step(1'b0, 1'b1, 32'h204, 32'h1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(4, 1'b1);
    check_eq("gr0_delta_beat_count", 32'(obs_beats), 32'd2);

    // Full dump under random backpressure with writebacks landing mid-record.
    step(1'b0, 1'b1, 32'h300, 32'h5, 1'b1, 5'd9, 32'h9999, 1'b1, 1'b1);
    for (int i = 0; i < 120; i++) rnd_step(0, 50, 0);
    idle(40, 1'b1);

    // Retire every cycle in delta mode: back-to-back records plus drops.
    for (int i = 0; i < 60; i++) rnd_step(100, 100, 0);
    idle(4, 1'b1);

    // Long stall to saturate the drop counter.
    step(1'b0, 1'b1, 32'h400, 32'h2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) rnd_step(100, 0, 50);
    check_eq("drop_saturated", 32'(drop_cnt), DROP_MAX);
    idle(40, 1'b1);

    // Reset during the 10th beat of a full dump.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 32'hA5A5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h500, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle(9, 1'b1);
    step(1'b1, 1'b1, 32'h600, 32'h4, 1'b1, 5'd4, 32'h4444, 1'b1, 1'b1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_cnt), 32'd0);
    step(1'b0, 1'b1, 32'h700, 32'h6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle(36, 1'b1);

    // Free-running random traffic.
    for (int i = 0; i < 2000; i++) rnd_step(30, 70, 20);
    idle(80, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_trace_sequencer.md
# gpr_trace_sequencer

Testbench-side controller that turns the CPU sub-system retire and GPR-writeback strobes into an ordered stream of trace beats for a downstream log sink. It keeps a shadow GPR file and snapshots it at each accepted retire. It then sequences PC, PSR and register beats over a valid/ready handshake, in either full-dump or delta mode. It sits between the `biu_pad_*` / `cp0_pad_mcause` observation points and any file writer or trace consumer, replacing direct per-cycle printing.

## Interface
- `CNT_W`, 16: width of the drop counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `retire`  in  1  instruction retired this cycle.
- `retire_pc`  in  32  PC of the retiring instruction.
- `psr`  in  32  status word sampled with `retire`.
- `wb_gpr_en`  in  1  GPR writeback valid.
- `wb_gpr_index`  in  5  writeback register index.
- `wb_gpr_data`  in  32  writeback data.
- `cfg_full`  in  1  1 = full 32-register dump, 0 = delta; sampled at accept.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_kind`  out  2  0 = PC, 1 = PSR, 2 = GPR.
- `out_idx`  out  5  register index for GPR beats, 0 otherwise.
- `out_data`  out  32  beat payload.
- `out_last`  out  1  final beat of the record.
- `busy`  out  1  record in progress.
- `drop_cnt`  out  CNT_W  retires dropped while busy; saturating.

## Operation
- Shadow file: 32×32, all zero after reset. Written when `wb_gpr_en` is high and `wb_gpr_index != 0`. Writes to index 0 are ignored, so gr0 reads 0.
- Accept: a retire is accepted when the FSM is IDLE, or in the cycle the `out_last` beat handshakes (back-to-back).
- On accept, the block latches `retire_pc`, `psr` and `cfg_full`, and copies the shadow file into the snapshot. A same-cycle writeback is bypassed into the snapshot and delta slot.
- Delta slot: `{en, idx, data}`. Captured from the same-cycle writeback; `en` = `wb_gpr_en && idx != 0`.
- FSM states: IDLE → PC → PSR → (full: GPR, counter 0..31 | delta: DGPR when slot `en`, else none) → IDLE, or straight to PC on a back-to-back accept.
- Beat order, full mode: PC, PSR, gr0..gr31. That is 34 beats, with `out_last` on gr31.
- Beat order, delta mode: PC, PSR, then one GPR beat if slot `en`. That is 3 beats with `out_last` on the GPR beat, or 2 beats with `out_last` on PSR.
- Handshake: a beat advances only when `out_valid && out_ready`. While stalled, `out_kind`, `out_idx`, `out_data` and `out_last` stay stable. `out_valid` does not drop until the handshake.
- Drop: a retire that is not accepted increments `drop_cnt`, which saturates at all-ones. The shadow file still takes writebacks every cycle regardless of FSM state.
- Reset: `rst` mid-record returns the FSM to IDLE and clears the shadow, snapshot, slot and `drop_cnt`. Any retire in the reset cycle is ignored and not counted.

## Timing
- Reset values: `out_valid` 0, `out_kind` 0, `out_idx` 0, `out_data` 0, `out_last` 0, `busy` 0, `drop_cnt` 0.
- Accept in cycle N → `out_valid` high with the PC beat from N+1.
- With `out_ready` held high, the final beat is in N+34 (full) or N+2 / N+3 (delta).
- Back-to-back: when the last beat handshakes in cycle M together with a new retire, the next PC beat appears in M+1. There are no bubble cycles.
- `busy` = FSM not IDLE. Registered outputs only; there are no combinational paths from inputs to outputs.

## Structure
- Package `gpr_trace_pkg`:
  - kind constants `KIND_PC` / `KIND_PSR` / `KIND_GPR`
  - FSM state enum (IDLE, PC, PSR, GPR, DGPR)
  - `NUM_GPR = 32`
  - `FULL_BEATS = 34`
- Sub-module `gpr_shadow_file`:
  - write port with index-0 masking
  - same-cycle bypass
  - snapshot copy and a registered read port indexed by the FSM counter
- Top level holds the FSM, beat mux, delta slot and drop counter.

## Test plan
- Reset → writeback gr5=0x1234 → retire PC=0x80, PSR=0x3, full mode, `out_ready`=1 → 34 beats: 0x80, 0x3, gr0=0, gr5=0x1234, all others 0. `out_last` only on gr31.
- Same-cycle retire PC=0x100 and writeback gr7=0xDEAD, delta mode → exactly 3 beats: PC 0x100, PSR, GPR idx 7 data 0xDEAD with `out_last`.
- Writeback to gr0 with data 0xFFFF_FFFF, then full dump → gr0 beat reads 0. Delta retire with the same write → 2 beats, `out_last` on PSR.
- Random `out_ready` toggling during a full dump → no beat lost or duplicated, and payload is stable while `out_valid && !out_ready`.
- Retires every cycle in delta mode with `out_ready`=1 → records back-to-back, retires during busy counted in `drop_cnt`. Preset `drop_cnt` to all-ones via a long stall → stays all-ones.
- Assert `rst` in the 10th beat of a full dump → next cycle `out_valid`=0, `busy`=0, `drop_cnt`=0. A following full dump shows all-zero GPRs.
